// File: rtl/zdos_trap.sv
// zdos_trap: DOS-mode controller sitting between Z80 strobe decode and the
// ROM/RAM page mapper.
//
// DOS mode is entered by:
//  - an opcode fetch from the trap page while BASIC48 ROM is selected,
//  - an opcode fetch at NMI_VEC after an accepted NMI,
//  - the cpm level,
//  - a software set pulse.
// DOS mode is left by:
//  - an opcode fetch outside the ROM area (4000-FFFF),
//  - a software clear pulse.
//
// Ports:
//   fclk         system clock
//   rst_n        asynchronous active-low reset
//   m1_fetch     one-cycle pulse per opcode fetch; za valid in the same cycle
//   za[15:0]     Z80 address bus
//   rom48        BASIC48 ROM page currently selected
//   cpm          level; forces dos=1 and blocks all clearing
//   nmi_req      one-cycle pulse, NMI accepted by the CPU
//   dos_turn_on  software set pulse
//   dos_turn_off software clear pulse
//   dos          DOS mode flag (registered)
//   dos_change   one-cycle pulse whenever dos toggles
//   trap_hit     one-cycle pulse when the address trap sets dos
//   nmi_armed    NMI entry pending
module zdos_trap #(
  parameter logic [7:0]  TRAP_PAGE = 8'h3D,
  parameter logic        TRAP_EN   = 1'b1,
  parameter logic        NMI_DOS   = 1'b1,
  parameter logic [15:0] NMI_VEC   = 16'h0066
) (
  input  logic        fclk,
  input  logic        rst_n,
  input  logic        m1_fetch,
  input  logic [15:0] za,
  input  logic        rom48,
  input  logic        cpm,
  input  logic        nmi_req,
  input  logic        dos_turn_on,
  input  logic        dos_turn_off,
  output logic        dos,
  output logic        dos_change,
  output logic        trap_hit,
  output logic        nmi_armed
);

  // State is the pair {dos, nmi_armed}. ON with a pending arm is possible
  // because an NMI accepted while already in DOS still arms entry.
  typedef enum logic [1:0] {
    ST_OFF      = 2'b00,
    ST_ARMED    = 2'b01,
    ST_ON       = 2'b10,
    ST_ON_ARMED = 2'b11
  } state_t;

  state_t state, state_nxt;
  logic   dos_q, arm_q;
  logic   dos_nxt, arm_nxt;
  logic   trap_nxt;
  logic   nmi_entry, addr_trap, rom_leave;

  assign dos_q = state[1];
  assign arm_q = state[0];

  always_comb begin
    nmi_entry = NMI_DOS && m1_fetch && arm_q && (za == NMI_VEC);
    addr_trap = TRAP_EN && m1_fetch && rom48 && (za[15:8] == TRAP_PAGE) && !dos_q;
    rom_leave = m1_fetch && (za[15:14] != 2'b00) && dos_q;

    dos_nxt  = dos_q;
    trap_nxt = 1'b0;
    if (cpm)               dos_nxt = 1'b1;
    else if (dos_turn_off) dos_nxt = 1'b0;
    else if (dos_turn_on)  dos_nxt = 1'b1;
    else if (nmi_entry)    dos_nxt = 1'b1;
    else if (addr_trap) begin
      dos_nxt  = 1'b1;
      trap_nxt = 1'b1;
    end
    else if (rom_leave)    dos_nxt = 1'b0;

    // Arm bookkeeping is independent of which rule picked dos: a completing
    // fetch consumes the arm, a coincident nmi_req re-arms, turn_off wins.
    arm_nxt = arm_q;
    if (nmi_entry)            arm_nxt = 1'b0;
    if (NMI_DOS && nmi_req)   arm_nxt = 1'b1;
    if (dos_turn_off)         arm_nxt = 1'b0;

    state_nxt = state_t'({dos_nxt, arm_nxt});
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_OFF;
      dos_change <= 1'b0;
      trap_hit   <= 1'b0;
    end else begin
      state      <= state_nxt;
      dos_change <= (dos_nxt != dos_q);
      trap_hit   <= trap_nxt;
    end
  end

  assign dos       = dos_q;
  assign nmi_armed = arm_q;

endmodule

// File: doc/zdos_trap.md
Name: zdos_trap

Overview:
- Parametrised DOS-mode controller; the next generation of the plain DOS on/off flag.
- Sets DOS mode automatically when the CPU fetches an opcode from the trap page (3Dxx) while BASIC48 ROM is selected.
- Clears DOS mode on an opcode fetch outside the ROM area.
- Also supports NMI-entry arming, CP/M force mode and explicit software on/off pulses. Sits between Z80 strobe decode and the ROM/RAM page mapper.

Parameters:
- TRAP_PAGE, 8'h3D, value of za[15:8] that triggers DOS entry.
- TRAP_EN, 1, 1 enables address-trap entry; 0 disables it, leaving only explicit, NMI and cpm entry.
- NMI_DOS, 1, 1 enables NMI-armed entry at NMI_VEC.
- NMI_VEC, 16'h0066, opcode fetch address that completes NMI-armed entry.

Ports:
- fclk in 1: system clock.
- rst_n in 1: asynchronous active-low reset.
- m1_fetch in 1: one-fclk pulse per opcode fetch; za is valid in the same cycle.
- za in 16: Z80 address bus.
- rom48 in 1: 1 = BASIC48 ROM page currently selected.
- cpm in 1: level; 1 forces dos=1 and blocks all clearing.
- nmi_req in 1: one-cycle pulse, NMI accepted by the CPU.
- dos_turn_on in 1: software set pulse.
- dos_turn_off in 1: software clear pulse.
- dos out 1: DOS mode flag (registered).
- dos_change out 1: one-cycle pulse whenever dos toggles.
- trap_hit out 1: one-cycle pulse when the address trap sets dos.
- nmi_armed out 1: NMI entry pending.

Behaviour:
- Reset (async, rst_n=0): dos=0, dos_change=0, trap_hit=0, nmi_armed=0. Outputs are held while rst_n=0. Reset mid-operation drops any pending NMI arm.
- All state updates on posedge fclk. Latency is one clock from the qualifying input to the dos change.
- Effective state is an FSM derived from {dos, nmi_armed}: OFF (0,0), ARMED (0,1), ON (1,x).
- Next-dos priority, highest first:
  1. cpm=1 -> dos=1.
  2. dos_turn_off -> dos=0; nmi_armed cleared.
  3. dos_turn_on -> dos=1.
  4. m1_fetch with nmi_armed and za==NMI_VEC -> dos=1; nmi_armed cleared.
  5. m1_fetch, TRAP_EN=1, rom48=1, za[15:8]==TRAP_PAGE, dos=0 -> dos=1; trap_hit pulses.
  6. m1_fetch, za[15:14]!=2'b00, dos=1 -> dos=0.
  7. Otherwise dos holds.
- Fetches at 0000–3FFF that do not hit the trap leave dos unchanged.
- Trap while dos=1: no effect and no trap_hit.
- nmi_req (NMI_DOS=1): sets nmi_armed the next clock unless dos_turn_off is asserted the same cycle (turn_off wins).
  - If nmi_req coincides with the completing fetch, the arm re-sets.
  - NMI_DOS=0: nmi_req is ignored and nmi_armed stays 0.
- An armed NMI survives non-matching fetches; it clears only via the NMI_VEC fetch, dos_turn_off or reset.
- dos_turn_on and dos_turn_off in the same cycle: off wins (unless cpm=1).
- cpm falling: dos keeps its value until the next clear condition.
- dos_change = registered (dos_next != dos), aligned with the dos update. trap_hit is aligned the same way.
- rom48 and za are sampled only when m1_fetch=1. Between fetches, changes have no effect.

Test Plan:
- Reset, rom48=1, m1_fetch at za=3D2F -> next clock dos=1, trap_hit=1, dos_change=1; fetch at 8000 -> dos=0, dos_change=1.
- rom48=0, fetch at 3D00 -> dos stays 0, no pulses; fetch at 1234 while dos=1 -> dos stays 1.
- nmi_req -> nmi_armed=1; fetch 0038 -> no change; fetch 0066 -> dos=1, nmi_armed=0; repeat with NMI_DOS=0 -> nmi_armed never set.
- cpm=1 with fetch at C000 and dos_turn_off pulse -> dos stays 1; drop cpm, fetch 4000 -> dos=0.
- dos_turn_on and dos_turn_off pulsed together while dos=0, nmi_armed=1 -> dos=0, nmi_armed=0, no dos_change.
- Assert rst_n=0 asynchronously mid-stream with dos=1, nmi_armed=1 -> both 0 immediately without a clock edge; TRAP_EN=0 build ignores 3Dxx fetches.
